// File: rtl/nes_poll_controller.sv
// NES pad poller: latch pulse, seven shift clocks and eight samples per read,
// then presents the decoded button byte with a one-cycle valid strobe.
module nes_poll_controller #(
   parameter int TICK_DIV    = 288,
   parameter int POLL_PERIOD = 800000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       auto_en,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic       buttons_valid,
   output logic       busy
);

   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int POLL_W = $clog2(POLL_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLK_HI, DONE} state_t;

   state_t            state, stateNext;
   logic [TICK_W-1:0] tickCnt;
   logic              tickLast;
   logic [2:0]        bitIdx, bitIdxNext;
   logic              pending, pendingNext;
   logic [POLL_W-1:0] pollCnt;
   logic              autoTick;
   logic              trigger;
   logic              dataSync_p0, dataSync_p1;
   logic [6:0]        raw;
   logic              sampleEn;
   logic              loadButtons;

   // Stage p0/p1: pad data synchronizer, idles at the released (1) level
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dataSync_p0 <= 1'b1;
         dataSync_p1 <= 1'b1;
      end else begin
         dataSync_p0 <= nes_data;
         dataSync_p1 <= dataSync_p0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pollCnt <= '0;
      else if (!auto_en || pollCnt == POLL_LAST)
         pollCnt <= '0;
      else
         pollCnt <= pollCnt + 1'b1;
   end

   assign autoTick = auto_en && (pollCnt == POLL_LAST);
   assign trigger  = start | autoTick;
   assign tickLast = (tickCnt == TICK_LAST);

   // Prescaler restarts whenever the state changes so every phase gets full ticks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tickCnt <= '0;
      else if (busy && stateNext == state && !tickLast)
         tickCnt <= tickCnt + 1'b1;
      else
         tickCnt <= '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bitIdx  <= '0;
         pending <= 1'b0;
      end else begin
         state   <= stateNext;
         bitIdx  <= bitIdxNext;
         pending <= pendingNext;
      end
   end

   always_comb begin
      stateNext     = state;
      bitIdxNext    = bitIdx;
      pendingNext   = pending;
      sampleEn      = 1'b0;
      loadButtons   = 1'b0;
      nes_latch     = 1'b0;
      nes_clk       = 1'b0;
      buttons_valid = 1'b0;
      busy          = (state != IDLE);
      if (busy && trigger)
         pendingNext = 1'b1;
      case (state)
         IDLE: begin
            if (trigger || pending) begin
               stateNext   = LATCH;
               pendingNext = 1'b0;
               bitIdxNext  = '0;
            end
         end
         LATCH: begin
            // bitIdx counts the two latch ticks before it becomes the bit index
            nes_latch = 1'b1;
            if (tickLast) begin
               if (bitIdx == 3'd1) begin
                  stateNext  = SAMPLE;
                  bitIdxNext = '0;
               end else begin
                  bitIdxNext = 3'd1;
               end
            end
         end
         SAMPLE: begin
            if (tickLast) begin
               sampleEn = 1'b1;
               if (bitIdx == 3'd7) begin
                  stateNext   = DONE;
                  loadButtons = 1'b1;
               end else begin
                  stateNext = CLK_HI;
               end
            end
         end
         CLK_HI: begin
            nes_clk = 1'b1;
            if (tickLast) begin
               bitIdxNext = bitIdx + 3'd1;
               stateNext  = SAMPLE;
            end
         end
         DONE: begin
            buttons_valid = 1'b1;
            if (pending) begin
               stateNext   = LATCH;
               pendingNext = 1'b0;
               bitIdxNext  = '0;
            end else begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // Stage p2: bit capture; the last bit goes straight into the output byte
   always_ff @(posedge clk) begin
      if (sampleEn && bitIdx != 3'd7)
         raw[bitIdx] <= dataSync_p1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         buttons <= 8'h00;
      else if (loadButtons)
         buttons <= ~{dataSync_p1, raw};
   end

endmodule

// File: tb/tb_nes_poll_controller.sv
// Bench for nes_poll_controller with a CD4021-style pad model and a button-byte
// scoreboard (TICK_DIV=4, POLL_PERIOD=100).
module tb_nes_poll_controller;

   localparam int TICK_DIV    = 4;
   localparam int POLL_PERIOD = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       auto_en;
   logic       nes_data;
   logic       nes_latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       buttons_valid;
   logic       busy;

   nes_poll_controller #(.TICK_DIV(TICK_DIV), .POLL_PERIOD(POLL_PERIOD)) dut (
      .clk(clk), .reset(reset), .start(start), .auto_en(auto_en), .nes_data(nes_data),
      .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
      .buttons_valid(buttons_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pad: parallel load while latched, shift toward bit 0 on each nes_clk rise.
   // padMode: 0 pad, 1 line held high, 2 line held low, 3 pad inverted while nes_clk high
   logic [7:0] pressed = 8'h00;
   logic [7:0] padReg  = 8'hFF;
   logic [1:0] padMode = 2'd0;
   logic       clkPrev = 1'b0;

   always @(negedge clk) begin
      if (nes_latch)
         padReg <= ~pressed;
      else if (nes_clk && !clkPrev)
         padReg <= {1'b1, padReg[7:1]};
      clkPrev <= nes_clk;
   end

   always_comb begin
      nes_data = 1'b1;
      case (padMode)
         2'd0: nes_data = padReg[0];
         2'd1: nes_data = 1'b1;
         2'd2: nes_data = 1'b0;
         default: nes_data = padReg[0] ^ nes_clk;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected bytes queued when a poll is requested, consumed on each strobe.
   logic [7:0] expQ[$];
   logic [7:0] expHead;
   int         validCount = 0;

   always @(negedge clk) begin
      if (buttons_valid) begin
         validCount++;
         if (expQ.size() == 0) begin
            check("unexpected_valid", 32'(buttons_valid), 32'd0);
         end else begin
            expHead = expQ.pop_front();
            check("buttons", 32'(buttons), 32'(expHead));
         end
      end
   end

   task automatic checkResetState(input string tag);
      check({tag, "_latch"}, 32'(nes_latch), 32'd0);
      check({tag, "_clk"}, 32'(nes_clk), 32'd0);
      check({tag, "_valid"}, 32'(buttons_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_buttons"}, 32'(buttons), 32'h00);
   endtask

   task automatic waitValid(input int prev, input string name);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (validCount > prev) return;
      end
      check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic doPoll(input logic [7:0] p, input logic [1:0] m, input logic [7:0] e, input string name);
      int prev;
      pressed = p;
      padMode = m;
      @(negedge clk);
      prev  = validCount;
      start = 1'b1;
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
      waitValid(prev, name);
      repeat (3) @(negedge clk);
   endtask

   task automatic asyncReset(input int dly, input string tag);
      #(dly) reset = 1'b1;
      #1 checkResetState(tag);
      expQ.delete();
      @(negedge clk);
      checkResetState({tag, "_held"});
      reset = 1'b0;
   endtask

   typedef struct {
      logic [7:0] pressed;
      logic [1:0] mode;
      logic [7:0] expBtn;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int nv;
      int vpos[4];
      int lrise[4];
      int nl;
      logic latchPrev;
      logic expLatch, expClk, expValid, expBusy;
      int off;
      int prev;

      vecs[0] = '{8'h00, 2'd0, 8'h00};
      vecs[1] = '{8'hFF, 2'd0, 8'hFF};
      vecs[2] = '{8'hA5, 2'd0, 8'hA5};
      vecs[3] = '{8'h80, 2'd0, 8'h80};
      vecs[4] = '{8'h5A, 2'd1, 8'h00};
      vecs[5] = '{8'h5A, 2'd2, 8'hFF};
      vecs[6] = '{8'h5A, 2'd3, 8'h5A};
      vecs[7] = '{8'h01, 2'd3, 8'h01};

      reset   = 1'b1;
      start   = 1'b0;
      auto_en = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState("por");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Single poll, A+Up, cycle-exact waveform
      pressed = 8'h11;
      padMode = 2'd0;
      @(negedge clk);
      base  = cyc;
      start = 1'b1;
      expQ.push_back(8'h11);
      for (int r = 1; r <= 72; r++) begin
         @(negedge clk);
         start    = 1'b0;
         expLatch = (r >= 1 && r <= 8);
         off      = r - 9;
         expClk   = (r >= 9 && r <= 64) && ((off % 8) >= 4);
         expValid = (r == 69);
         expBusy  = (r >= 1 && r <= 69);
         check($sformatf("latch@%0d", cyc - base), 32'(nes_latch), 32'(expLatch));
         check($sformatf("nesclk@%0d", cyc - base), 32'(nes_clk), 32'(expClk));
         check($sformatf("valid@%0d", cyc - base), 32'(buttons_valid), 32'(expValid));
         check($sformatf("busy@%0d", cyc - base), 32'(busy), 32'(expBusy));
      end
      check("buttons_hold", 32'(buttons), 32'h11);

      // Pattern table
      foreach (vecs[i])
         doPoll(vecs[i].pressed, vecs[i].mode, vecs[i].expBtn, $sformatf("vec%0d", i));

      // Starts at 0, 20, 30: one queued, one dropped
      pressed = 8'h81;
      padMode = 2'd0;
      @(negedge clk);
      base      = cyc;
      start     = 1'b1;
      expQ.push_back(8'h81);
      expQ.push_back(8'h81);
      nv        = 0;
      nl        = 0;
      latchPrev = 1'b0;
      for (int r = 1; r <= 220; r++) begin
         @(negedge clk);
         start = (r == 20 || r == 30);
         if (buttons_valid && nv < 4) begin vpos[nv] = r; nv++; end
         if (nes_latch && !latchPrev && nl < 4) begin lrise[nl] = r; nl++; end
         latchPrev = nes_latch;
      end
      check("q_valid_count", 32'(nv), 32'd2);
      check("q_valid0", 32'(vpos[0]), 32'd69);
      check("q_valid1", 32'(vpos[1]), 32'd138);
      check("q_latch_rises", 32'(nl), 32'd2);
      check("q_latch_rise1", 32'(lrise[1]), 32'd70);

      // Auto-poll, disabled at cycle 250
      pressed = 8'h42;
      @(negedge clk);
      base      = cyc;
      auto_en   = 1'b1;
      expQ.push_back(8'h42);
      expQ.push_back(8'h42);
      nv        = 0;
      nl        = 0;
      latchPrev = 1'b0;
      for (int r = 1; r <= 400; r++) begin
         @(negedge clk);
         auto_en = (r < 250);
         if (buttons_valid && nv < 4) begin vpos[nv] = r; nv++; end
         if (nes_latch && !latchPrev && nl < 4) begin lrise[nl] = r; nl++; end
         latchPrev = nes_latch;
      end
      auto_en = 1'b0;
      check("a_valid_count", 32'(nv), 32'd2);
      check("a_valid0", 32'(vpos[0]), 32'd168);
      check("a_valid1", 32'(vpos[1]), 32'd268);
      check("a_latch_rises", 32'(nl), 32'd2);
      check("a_latch_rise0", 32'(lrise[0]), 32'd100);
      check("a_latch_rise1", 32'(lrise[1]), 32'd200);

      // Resets at random points of a poll
      for (int k = 0; k < 3; k++) begin
         pressed = 8'(k * 8'h37 + 8'h0F);
         padMode = 2'd0;
         @(negedge clk);
         start = 1'b1;
         expQ.push_back(pressed);
         @(negedge clk);
         start = 1'b0;
         repeat ($urandom_range(2, 60)) @(negedge clk);
         asyncReset(int'($urandom_range(1, 3) + 5 * $urandom_range(0, 1)), $sformatf("rst%0d", k));
         prev = validCount;
         repeat (80) @(negedge clk);
         check($sformatf("rst%0d_no_valid", k), 32'(validCount - prev), 32'd0);
      end

      // Reset during CLK_HI of bit 3, then a clean poll
      pressed = 8'h3C;
      @(negedge clk);
      base  = cyc;
      start = 1'b1;
      expQ.push_back(8'h3C);
      for (int r = 1; r <= 38; r++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("b3_clk_high", 32'(nes_clk), 32'd1);
      asyncReset(2, "b3rst");
      prev = validCount;
      repeat (100) @(negedge clk);
      check("b3_no_valid", 32'(validCount - prev), 32'd0);
      doPoll(8'hC3, 2'd0, 8'hC3, "after_rst");
      check("after_rst_buttons", 32'(buttons), 32'hC3);
      check("scoreboard_empty", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
